// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic unit (AND/OR/XOR/NAND)
// among NUM_REQ valid/ready requesters, with a single held response channel.
module logic_unit_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]     req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_y,
  output logic [ID_W-1:0]          rsp_id
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t            state, state_d;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cand;
  logic              found;
  logic              do_grant;
  logic              do_ack;
  logic [WIDTH-1:0]  op_a, op_b, op_y;
  logic [1:0]        op_sel;

  // Scan starting just after the last winner so each requester waits at most one round.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand = ID_W'((int'(last_grant) + k) % int'(NUM_REQ));
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    op_a   = req_a[int'(winner)*int'(WIDTH) +: WIDTH];
    op_b   = req_b[int'(winner)*int'(WIDTH) +: WIDTH];
    op_sel = req_op[int'(winner)*2 +: 2];
    case (op_sel)
      2'b00:   op_y = op_a & op_b;
      2'b01:   op_y = op_a | op_b;
      2'b10:   op_y = op_a ^ op_b;
      default: op_y = ~(op_a & op_b);
    endcase
  end

  // Next-state and handshake decode; reset suppresses any grant in the same cycle.
  always_comb begin
    state_d   = state;
    req_ready = '0;
    do_grant  = 1'b0;
    do_ack    = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && found) begin
          req_ready[winner] = 1'b1;
          do_grant          = 1'b1;
          state_d           = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          do_ack  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      rsp_valid  <= 1'b0;
      rsp_y      <= '0;
      rsp_id     <= '0;
    end else begin
      state <= state_d;
      if (do_grant) begin
        rsp_y      <= op_y;
        rsp_id     <= winner;
        last_grant <= winner;
        rsp_valid  <= 1'b1;
      end else if (do_ack) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter (NUM_REQ=4, WIDTH=8).
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_y;
  logic [1:0]  rsp_id;

  int errors = 0;
  int checks = 0;

  logic unit_arbiter_dummy;

  logic_unit_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_y !== 8'h00 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL reset_state: got v=%b y=%h id=%0d want v=0 y=00 id=0", rsp_valid, rsp_y, rsp_id);
    end
    req_valid = 4'b0000; rst = 1'b0;
  endtask

  task automatic test_single();
    req_valid = 4'b0100; req_a[23:16] = 8'hF0; req_b[23:16] = 8'h3C; req_op[5:4] = 2'b00;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_y !== 8'h30 || rsp_id !== 2'd2) begin
      errors++; $display("FAIL single_rsp: got v=%b y=%h id=%0d want v=1 y=30 id=2", rsp_valid, rsp_y, rsp_id);
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_y !== 8'h30) begin
      errors++; $display("FAIL single_ack: got v=%b y=%h want v=0 y=30", rsp_valid, rsp_y);
    end
  endtask

  task automatic test_opcodes();
    logic [7:0] exp_y [3] = '{8'hAF, 8'hA5, 8'hF5};
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'b0001; req_a[7:0] = 8'hAA; req_b[7:0] = 8'h0F; req_op[1:0] = 2'(i + 1);
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL op%0d_ready: got %b want 0001", i + 1, req_ready); end
      tick();
      req_valid = 4'b0000;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_y !== exp_y[i] || rsp_id !== 2'd0) begin
        errors++; $display("FAIL op%0d_rsp: got v=%b y=%h id=%0d want v=1 y=%h id=0", i + 1, rsp_valid, rsp_y, rsp_id, exp_y[i]);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int exp_id [6] = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1; tick(); rst = 1'b0;
    req_a = 32'h44332211; req_b = 32'hFFFFFFFF; req_op = 8'h00;
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (req_ready !== 4'(1 << exp_id[i])) begin
        errors++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, 4'(1 << exp_id[i]));
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id[i]) || rsp_y !== 8'(8'h11 * (exp_id[i] + 1)) || req_ready !== 4'b0000) begin
        errors++; $display("FAIL rr_rsp%0d: got v=%b id=%0d y=%h rdy=%b want v=1 id=%0d y=%h rdy=0000",
                           i, rsp_valid, rsp_id, rsp_y, req_ready, exp_id[i], 8'(8'h11 * (exp_id[i] + 1)));
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_y !== 8'h33 || rsp_id !== 2'd2 || req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b y=%h id=%0d rdy=%b want v=1 y=33 id=2 rdy=0000",
                           i, rsp_valid, rsp_y, rsp_id, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
      errors++; $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1000", rsp_valid, req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_y !== 8'h44) begin
      errors++; $display("FAIL bp_next: got v=%b id=%0d y=%h want v=1 id=3 y=44", rsp_valid, rsp_id, rsp_y);
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_fairness_skip();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    tick();
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL skip_first: got %b want 1000", req_ready); end
    tick();
    req_valid = 4'b0001;
    checks++;
    if (rsp_id !== 2'd3) begin errors++; $display("FAIL skip_id3: got %0d want 3", rsp_id); end
    tick();
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL skip_second: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (rsp_id !== 2'd0 || rsp_valid !== 1'b1) begin
      errors++; $display("FAIL skip_id0: got id=%0d v=%b want id=0 v=1", rsp_id, rsp_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0000; rsp_ready = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin
      errors++; $display("FAIL mid_pre: got v=%b id=%0d want v=1 id=3", rsp_valid, rsp_id);
    end
    rst = 1'b1; req_valid = 4'b0110;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b want 0000", req_ready); end
    tick();
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_y !== 8'h00 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL mid_cleared: got v=%b y=%h id=%0d want v=0 y=00 id=0", rsp_valid, rsp_y, rsp_id);
    end
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_regrant: got %b want 0010", req_ready); end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_y !== 8'h22) begin
      errors++; $display("FAIL mid_rsp: got v=%b id=%0d y=%h want v=1 id=1 y=22", rsp_valid, rsp_id, rsp_y);
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_opcodes();
    test_round_robin();
    test_backpressure();
    test_fairness_skip();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
